control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//   Multi-cycle control unit; drives the control side of the processor datapath.
//   Inputs: opcode/funct fields and ALU flags from the datapath.
//   Outputs: PC, ALU, mux, sign-extend, data-memory write and regfile write controls.
//   Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
//   Handles data-memory access with a req/ready handshake and a timeout.
// PARAMETERS
//   MEM_TIMEOUT  15  max cycles in MEM waiting for mem_ready before error halt (1..255)
// PORTS
//   clk         in   1  clock; all state updates on rising edge
//   areset      in   1  reset, synchronous, active-high
//   OP          in   7  instruction opcode (Inst[6:0])
//   Funct3      in   3  Inst[14:12]
//   Funct7      in   1  Inst[30]
//   ZF          in   1  ALU zero flag
//   SF          in   1  ALU sign flag
//   mem_ready   in   1  data memory completed access this cycle
//   PCSrc       out  1  1 = PC+ImmExt, 0 = PC+4
//   PCLoad      out  1  PC update strobe (exactly one cycle per retired instruction)
//   ALUControl  out  3  000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLT,110 SLL,111 SRL
//   ALUSrc      out  1  0 = RD2, 1 = ImmExt
//   ResultSrc   out  1  0 = ALU result, 1 = memory data to regfile
//   SEControl   out  2  00 I-type, 01 S-type, 10 B-type
//   mem_req     out  1  data-memory access request, high throughout MEM state
//   WD          out  1  data-memory write enable (one-cycle pulse)
//   W           out  1  regfile write enable (one-cycle pulse)
//   halted      out  1  sticky; FSM in HALT
//   err_code    out  2  00 none, 01 illegal instruction, 10 memory timeout
// BEHAVIOUR
//   Reset: state=FETCH; all outputs 0; decode regs, timeout counter, err_code cleared.
//   Reset mid-instruction: no W/WD/PCLoad issued after the reset edge.
//   Outputs are decoded combinationally from the state register and the decode registers
//     (opcode class, alu_op, se_sel, branch cond) captured in DECODE.
//     Exceptions: PCSrc and ALU controls in EXEC use the live flags; WD/W are gated.
//   Decode (OP):
//     0110011 R-type: ALUSrc=0; SUB if Funct3=000 & Funct7=1.
//     0010011 I-ALU: ALUSrc=1, SE=00; Funct7 ignored except SRL/SLL pass.
//     0000011 LW: ADD, ALUSrc=1, SE=00.
//     0100011 SW: ADD, ALUSrc=1, SE=01.
//     1100011 BR: SUB, ALUSrc=0, SE=10.
//   Funct3->ALU: 000 ADD/SUB, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND;
//     011 is illegal.
//   Branch taken: 000 ZF, 001 !ZF, 100 SF, 101 !SF; other Funct3 values are illegal.
//   Any other OP is illegal.
//   Transitions:
//     FETCH->DECODE always.
//     DECODE->EXEC, or ->HALT (err 01) if illegal.
//     EXEC: R/I ->WB; LW/SW ->MEM; BR: PCLoad=1, PCSrc=taken ->FETCH (latency 3 cycles).
//     MEM: mem_req=1; counter increments each cycle without mem_ready.
//       LW + ready -> WB with ResultSrc=1.
//       SW + ready: WD=1 and PCLoad=1 in that cycle -> FETCH.
//       Counter reaching MEM_TIMEOUT -> HALT (err 10), no WD.
//       ready in the same cycle as the timeout: ready wins.
//     WB: W=1, PCLoad=1, PCSrc=0 -> FETCH (R/I: 4 cycles; LW: 5 + wait cycles).
//     HALT: all strobes 0, halted=1; exit only by reset.
//   ALU controls are held stable from EXEC through WB (and MEM) of the same instruction.
//   Counter saturates; cleared on MEM entry.
// TESTING
//   ADD (OP=0110011,F3=000,F7=0)
//     -> FETCH,DECODE,EXEC,WB; W=1 & PCLoad=1 only in cycle 4, ALUControl=000, ALUSrc=0.
//   SUB (F7=1) then BEQ with ZF=1 -> ALUControl=001; PCSrc=1,PCLoad=1 in branch EXEC.
//   BNE with ZF=1 -> PCSrc=0; no W pulse.
//   LW with mem_ready delayed 3 cycles
//     -> mem_req high 4 cycles, then WB with ResultSrc=1, W=1; SE=00.
//   SW with mem_ready=0 for MEM_TIMEOUT cycles -> halted=1, err_code=10, WD never pulses.
//   SW with mem_ready on the timeout cycle -> WD=1 once.
//   OP=1111111 -> halted=1, err_code=01 after DECODE.
//   areset in WB of a LW -> W=0 next cycle, state=FETCH, all outputs 0, err_code=00.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/WB.
// Instruction fields are decoded in DECODE and held in registers. Control
// outputs are then derived from the state and those registers. The data-memory
// access uses a req/ready handshake, guarded by a saturating timeout counter.
`timescale 1ns/1ps
module control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [6:0] OP,
  input  logic [2:0] Funct3,
  input  logic       Funct7,
  input  logic       ZF,
  input  logic       SF,
  input  logic       mem_ready,
  output logic       PCSrc,
  output logic       PCLoad,
  output logic [2:0] ALUControl,
  output logic       ALUSrc,
  output logic       ResultSrc,
  output logic [1:0] SEControl,
  output logic       mem_req,
  output logic       WD,
  output logic       W,
  output logic       halted,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BR} cls_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101,
                         ALU_SLL = 3'b110, ALU_SRL = 3'b111;

  // Last MEM count value before a ready-less cycle triggers the timeout.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state, w_state_next;
  cls_t       r_cls, w_cls;
  logic [2:0] r_alu, w_alu, w_alu_f3;
  logic       r_alusrc, w_alusrc;
  logic [1:0] r_se, w_se;
  logic [1:0] r_br;          // {use SF instead of ZF, invert condition}
  logic [7:0] r_cnt;
  logic [1:0] r_err;
  logic       w_illegal, w_f3_bad, w_taken, w_timeout;

  // Instruction decode from the live fields; only captured while in DECODE.
  always_comb begin
    w_alu_f3 = ALU_ADD;
    w_f3_bad = 1'b0;
    case (Funct3)
      3'b000:  w_alu_f3 = (OP == OP_R && Funct7) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      3'b111:  w_alu_f3 = ALU_AND;
      default: w_f3_bad = 1'b1;
    endcase

    w_cls     = C_R;
    w_alu     = ALU_ADD;
    w_alusrc  = 1'b0;
    w_se      = 2'b00;
    w_illegal = 1'b0;
    case (OP)
      OP_R:  begin w_cls = C_R;  w_alu = w_alu_f3; w_illegal = w_f3_bad; end
      OP_I:  begin w_cls = C_I;  w_alu = w_alu_f3; w_alusrc = 1'b1; w_illegal = w_f3_bad; end
      OP_LW: begin w_cls = C_LW; w_alusrc = 1'b1; end
      OP_SW: begin w_cls = C_SW; w_alusrc = 1'b1; w_se = 2'b01; end
      OP_BR: begin
        w_cls = C_BR;
        w_alu = ALU_SUB;
        w_se  = 2'b10;
        w_illegal = (Funct3[1] || Funct3 == 3'b011);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Branch outcome uses the live ALU flags in EXEC; MEM timeout detection.
  assign w_taken   = (r_br[1] ? SF : ZF) ^ r_br[0];
  assign w_timeout = !mem_ready && (r_cnt >= TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (areset) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Decode registers, MEM timeout counter and sticky error code.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_cls    <= C_R;
      r_alu    <= ALU_ADD;
      r_alusrc <= 1'b0;
      r_se     <= 2'b00;
      r_br     <= 2'b00;
      r_cnt    <= 8'd0;
      r_err    <= 2'b00;
    end else begin
      if (r_state == S_DECODE) begin
        r_cls    <= w_cls;
        r_alu    <= w_alu;
        r_alusrc <= w_alusrc;
        r_se     <= w_se;
        r_br     <= {Funct3[2], Funct3[0]};
        if (w_illegal) r_err <= 2'b01;
      end
      if (r_state == S_EXEC) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_MEM && !mem_ready && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == S_MEM && w_timeout) r_err <= 2'b10;
    end
  end

  // Next-state and control outputs; strobes default low in every state.
  always_comb begin
    w_state_next = r_state;
    PCSrc      = 1'b0;
    PCLoad     = 1'b0;
    ALUControl = 3'b000;
    ALUSrc     = 1'b0;
    ResultSrc  = 1'b0;
    SEControl  = 2'b00;
    mem_req    = 1'b0;
    WD         = 1'b0;
    W          = 1'b0;
    halted     = 1'b0;
    err_code   = r_err;
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      ALUControl = r_alu;
      ALUSrc     = r_alusrc;
      SEControl  = r_se;
    end
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = w_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (r_cls)
          C_LW, C_SW: w_state_next = S_MEM;
          C_BR: begin
            PCLoad       = 1'b1;
            PCSrc        = w_taken;
            w_state_next = S_FETCH;
          end
          default: w_state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if (r_cls == C_SW) begin
            WD           = 1'b1;
            PCLoad       = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_timeout) begin
          w_state_next = S_HALT;
        end
      end
      S_WB: begin
        W            = 1'b1;
        PCLoad       = 1'b1;
        ResultSrc    = (r_cls == C_LW);
        w_state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: w_state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each directed instruction pushes its
// expected strobe event (cycle, output vector, mem_req cycle count); an
// independent monitor pops and compares on every PCLoad/W/WD pulse or halt.
`timescale 1ns/1ps
module tb_control_fsm;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       areset, Funct7, ZF, SF, mem_ready;
  logic [6:0] OP;
  logic [2:0] Funct3;
  logic       PCSrc, PCLoad, ALUSrc, ResultSrc, mem_req, WD, W, halted;
  logic [2:0] ALUControl;
  logic [1:0] SEControl, err_code;

  control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .areset(areset), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
    .ZF(ZF), .SF(SF), .mem_ready(mem_ready), .PCSrc(PCSrc), .PCLoad(PCLoad),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ResultSrc(ResultSrc),
    .SEControl(SEControl), .mem_req(mem_req), .WD(WD), .W(W),
    .halted(halted), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [14:0] vec;
    int          mreq;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BR = 7'b1100011;

  // {PCSrc,PCLoad,ALUControl,ALUSrc,ResultSrc,SEControl,mem_req,WD,W,halted,err_code}
  function automatic logic [14:0] mk(input logic pcsrc, input logic pcload,
      input logic [2:0] alu, input logic alusrc, input logic rs, input logic [1:0] se,
      input logic mreq, input logic wd, input logic w, input logic hlt,
      input logic [1:0] err);
    return {pcsrc, pcload, alu, alusrc, rs, se, mreq, wd, w, hlt, err};
  endfunction

  function automatic logic [14:0] outs();
    return {PCSrc, PCLoad, ALUControl, ALUSrc, ResultSrc, SEControl,
            mem_req, WD, W, halted, err_code};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    chk("reset_outputs", outs(), 15'd0);
    areset = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; rdy is the MEM-cycle index at
  // which mem_ready pulses (-1: never). Leaves the bench n cycles later.
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic zf, input logic sf, input int rdy, input int n,
      input int ev_off, input logic [14:0] ev_vec, input int ev_mreq);
    exp_t e;
    int t0;
    t0 = cyc;
    e.cyc = t0 + ev_off; e.vec = ev_vec; e.mreq = ev_mreq; e.name = nm;
    sb_q.push_back(e);
    OP = op; Funct3 = f3; Funct7 = f7; ZF = zf; SF = sf;
    for (int k = 0; k < n; k++) begin
      mem_ready = (rdy >= 0) && (k == 3 + rdy);
      tick();
    end
    mem_ready = 1'b0;
  endtask

  // Monitor: an event is any strobe pulse or the rising edge of halted.
  initial begin
    logic        hp;
    logic [14:0] v;
    int          mcnt;
    exp_t        e;
    hp = 1'b0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) mcnt++;
      v = outs();
      if (PCLoad === 1'b1 || W === 1'b1 || WD === 1'b1 || (halted === 1'b1 && !hp)) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event cyc=%0d got=%b mreq=%0d expected=none", cyc, v, mcnt);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.vec !== v || e.mreq != mcnt) begin
            n_err++;
            $display("FAIL %s got cyc=%0d vec=%b mreq=%0d expected cyc=%0d vec=%b mreq=%0d",
                     e.name, cyc, v, mcnt, e.cyc, e.vec, e.mreq);
          end
        end
        mcnt = 0;
      end
      hp = (halted === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    OP = 7'd0; Funct3 = 3'd0; Funct7 = 1'b0; ZF = 1'b0; SF = 1'b0;
    mem_ready = 1'b0; areset = 1'b1;
    do_reset();

    // R/I-type ALU ops: single W+PCLoad pulse in the 4th cycle.
    run("add",  R, 3'b000, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b000,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("sub",  R, 3'b000, 1'b1, 0, 0, -1, 4, 3, mk(0,1,3'b001,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("sll",  R, 3'b001, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b110,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("srl",  R, 3'b101, 1'b1, 0, 0, -1, 4, 3, mk(0,1,3'b111,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("and",  R, 3'b111, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b010,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("or",   R, 3'b110, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b011,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("slt",  R, 3'b010, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b101,0,0,2'b00,0,0,1,0,2'b00), 0);
    run("xori", I, 3'b100, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b100,1,0,2'b00,0,0,1,0,2'b00), 0);
    run("addi_f7", I, 3'b000, 1'b1, 0, 0, -1, 4, 3, mk(0,1,3'b000,1,0,2'b00,0,0,1,0,2'b00), 0);

    // Branches: PCLoad in EXEC (3rd cycle), PCSrc from live flags.
    run("beq_t", BR, 3'b000, 1'b0, 1, 0, -1, 3, 2, mk(1,1,3'b001,0,0,2'b10,0,0,0,0,2'b00), 0);
    run("bne_nt", BR, 3'b001, 1'b0, 1, 0, -1, 3, 2, mk(0,1,3'b001,0,0,2'b10,0,0,0,0,2'b00), 0);
    run("blt_t", BR, 3'b100, 1'b0, 0, 1, -1, 3, 2, mk(1,1,3'b001,0,0,2'b10,0,0,0,0,2'b00), 0);
    run("bge_nt", BR, 3'b101, 1'b0, 0, 1, -1, 3, 2, mk(0,1,3'b001,0,0,2'b10,0,0,0,0,2'b00), 0);

    // Loads and stores.
    run("lw_wait3", LW, 3'b010, 1'b0, 0, 0, 3, 8, 7, mk(0,1,3'b000,1,1,2'b00,0,0,1,0,2'b00), 4);
    run("sw_fast", SW, 3'b010, 1'b0, 0, 0, 0, 4, 3, mk(0,1,3'b000,1,0,2'b01,1,1,0,0,2'b00), 1);
    run("sw_ready_at_to", SW, 3'b010, 1'b0, 0, 0, TO-1, TO+3, TO+2,
        mk(0,1,3'b000,1,0,2'b01,1,1,0,0,2'b00), TO);
    run("sw_timeout", SW, 3'b010, 1'b0, 0, 0, -1, TO+7, TO+3,
        mk(0,0,3'b000,0,0,2'b00,0,0,0,1,2'b10), TO);
    do_reset();

    // Illegal encodings halt right after DECODE.
    run("ill_op", 7'b1111111, 3'b000, 1'b0, 0, 0, -1, 5, 2, mk(0,0,3'b000,0,0,2'b00,0,0,0,1,2'b01), 0);
    do_reset();
    run("ill_r_f3", R, 3'b011, 1'b0, 0, 0, -1, 5, 2, mk(0,0,3'b000,0,0,2'b00,0,0,0,1,2'b01), 0);
    do_reset();
    run("ill_br_f3", BR, 3'b010, 1'b0, 0, 0, -1, 5, 2, mk(0,0,3'b000,0,0,2'b00,0,0,0,1,2'b01), 0);
    do_reset();

    // Reset asserted while a LW sits in WB: no W afterwards, clean outputs.
    run("lw_rst_wb", LW, 3'b010, 1'b0, 0, 0, 0, 4, 4, mk(0,1,3'b000,1,1,2'b00,0,0,1,0,2'b00), 1);
    areset = 1'b1;
    tick();
    chk("after_rst_in_wb", outs(), 15'd0);
    tick();
    areset = 1'b0;
    run("add_after_rst", R, 3'b000, 1'b0, 0, 0, -1, 4, 3, mk(0,1,3'b000,0,0,2'b00,0,0,1,0,2'b00), 0);

    tick();
    tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got=%0d expected=0 first=%s", sb_q.size(), sb_q[0].name);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
